// File: rtl/csi2_pkg.sv
// csi2_pkg: shared CSI-2 data types, FSM states, header ECC and payload CRC helpers
// Used by csi2_packet_decoder, csi2_crc16 and the TX model checker.
package csi2_pkg;
    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;
    typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_CRC, ST_DROP} state_e;
    // Each mask selects the header bits feeding one parity bit of the CSI-2 v1.x Hamming code.
    function automatic logic [7:0] ecc6(input logic [23:0] d);
        logic [7:0] e;
        e    = 8'h00;
        e[0] = ^(d & 24'hF12CB7);
        e[1] = ^(d & 24'hF2555B);
        e[2] = ^(d & 24'h749A6D);
        e[3] = ^(d & 24'hB8E38E);
        e[4] = ^(d & 24'hDF03F0);
        e[5] = ^(d & 24'hEFFC00);
        return e;
    endfunction
    // Reflected CRC-16/CCITT (0x8408), one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return c;
    endfunction
endpackage

// File: rtl/csi2_crc16.sv
// csi2_crc16: byte-wide CRC-16 accumulator over long-packet payload
// Ports: clk, reset (sync, active-high), clear_i (reload 0xFFFF), en_i (fold data_i),
//        data_i[7:0] payload byte, crc_o[15:0] running CRC.
module csi2_crc16
    import csi2_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);
    logic [15:0] crc_q;
    always_ff @(posedge clk) begin
        if (reset)        crc_q <= 16'h0000;
        else if (clear_i) crc_q <= 16'hFFFF;
        else if (en_i)    crc_q <= crc16_byte(crc_q, data_i);
    end
    assign crc_o = crc_q;
endmodule

// File: rtl/csi2_packet_decoder.sv
// csi2_packet_decoder: CSI-2 byte-stream packet decoder (header ECC check, frame/line tracking, payload out)
// Inputs : clk, reset (sync, active-high), rx_valid, rx_data[7:0], rx_eot (last byte of burst).
// Outputs: hdr_valid, vc, dt, word_count (last good header); frame_valid, line_valid,
//          frame_number, line_number; pixel_data, pixel_valid, pixel_last;
//          ecc_err, crc_err, len_err one-cycle status pulses. All outputs registered.
// Build option: CSI2_CRC_CHECK_EN enables payload CRC-16 checking; otherwise crc_err is 0.
module csi2_packet_decoder
    import csi2_pkg::*;
#(
    parameter int unsigned MAX_WORD_COUNT = 4096
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_eot,
    output logic        hdr_valid,
    output logic [1:0]  vc,
    output logic [5:0]  dt,
    output logic [15:0] word_count,
    output logic        frame_valid,
    output logic        line_valid,
    output logic [15:0] frame_number,
    output logic [15:0] line_number,
    output logic [7:0]  pixel_data,
    output logic        pixel_valid,
    output logic        pixel_last,
    output logic        ecc_err,
    output logic        crc_err,
    output logic        len_err
);
    localparam logic [16:0] MAX_WC = 17'(MAX_WORD_COUNT);
    state_e      state_q, state_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [7:0]  di_q, di_d;
    logic [15:0] wc_q, wc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        hdr_valid_q, hdr_valid_d;
    logic [1:0]  vc_q, vc_d;
    logic [5:0]  dt_q, dt_d;
    logic [15:0] word_count_q, word_count_d;
    logic        frame_valid_q, frame_valid_d;
    logic        line_valid_q, line_valid_d;
    logic [15:0] frame_number_q, frame_number_d;
    logic [15:0] line_number_q, line_number_d;
    logic [7:0]  pixel_data_q, pixel_data_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic        pixel_last_q, pixel_last_d;
    logic        ecc_err_q, ecc_err_d;
    logic        len_err_q, len_err_d;
`ifdef CSI2_CRC_CHECK_EN
    logic        crc_err_q, crc_err_d;
    logic [7:0]  crc_lo_q, crc_lo_d;
    logic        crc_clear, crc_en;
    logic [15:0] crc_val;
    csi2_crc16 u_crc (
        .clk     (clk),
        .reset   (reset),
        .clear_i (crc_clear),
        .en_i    (crc_en),
        .data_i  (rx_data),
        .crc_o   (crc_val)
    );
`endif
    // bcnt_q counts header bytes (1..3) in HEADER and CRC bytes (0..1) in CRC.
    always_comb begin
        state_d        = state_q;
        bcnt_d         = bcnt_q;
        di_d           = di_q;
        wc_d           = wc_q;
        cnt_d          = cnt_q;
        hdr_valid_d    = 1'b0;
        vc_d           = vc_q;
        dt_d           = dt_q;
        word_count_d   = word_count_q;
        frame_valid_d  = frame_valid_q;
        line_valid_d   = line_valid_q;
        frame_number_d = frame_number_q;
        line_number_d  = line_number_q;
        pixel_data_d   = pixel_data_q;
        pixel_valid_d  = 1'b0;
        pixel_last_d   = 1'b0;
        ecc_err_d      = 1'b0;
        len_err_d      = 1'b0;
`ifdef CSI2_CRC_CHECK_EN
        crc_err_d      = 1'b0;
        crc_lo_d       = crc_lo_q;
        crc_clear      = 1'b0;
        crc_en         = 1'b0;
`endif
        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    di_d      = rx_data;
                    bcnt_d    = 2'd1;
                    len_err_d = rx_eot;
                    state_d   = rx_eot ? ST_IDLE : ST_HEADER;
                end
                ST_HEADER: begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd1) wc_d[7:0] = rx_data;
                    if (bcnt_q == 2'd2) wc_d[15:8] = rx_data;
                    if (bcnt_q != 2'd3) begin
                        len_err_d = rx_eot;
                        state_d   = rx_eot ? ST_IDLE : ST_HEADER;
                    end else if (rx_data != ecc6({wc_q, di_q})) begin
                        ecc_err_d = 1'b1;
                        state_d   = rx_eot ? ST_IDLE : ST_DROP;
                    end else begin
                        hdr_valid_d  = 1'b1;
                        vc_d         = di_q[7:6];
                        dt_d         = di_q[5:0];
                        word_count_d = wc_q;
                        state_d      = ST_IDLE;
                        if (di_q[5:0] < DT_LONG_MIN) begin
                            if (di_q[5:0] == DT_FS) begin
                                frame_valid_d  = 1'b1;
                                frame_number_d = wc_q;
                            end
                            if (di_q[5:0] == DT_FE) begin
                                frame_valid_d = 1'b0;
                                line_valid_d  = 1'b0;
                            end
                            if (di_q[5:0] == DT_LS) begin
                                line_valid_d  = 1'b1;
                                line_number_d = wc_q;
                            end
                            if (di_q[5:0] == DT_LE) line_valid_d = 1'b0;
                        end else if (rx_eot) begin
                            len_err_d = 1'b1;
                        end else if ({1'b0, wc_q} > MAX_WC) begin
                            len_err_d = 1'b1;
                            state_d   = ST_DROP;
                        end else begin
                            state_d = (wc_q == 16'd0) ? ST_CRC : ST_PAYLOAD;
                            cnt_d   = wc_q;
                            bcnt_d  = 2'd0;
`ifdef CSI2_CRC_CHECK_EN
                            crc_clear = 1'b1;
`endif
                        end
                    end
                end
                ST_PAYLOAD: begin
                    pixel_valid_d = 1'b1;
                    pixel_data_d  = rx_data;
                    cnt_d         = cnt_q - 16'd1;
                    // A burst ending on the last payload byte still lacks its CRC, so it is truncated.
                    pixel_last_d  = (cnt_q == 16'd1) && !rx_eot;
                    len_err_d     = rx_eot;
                    state_d       = rx_eot ? ST_IDLE : (cnt_q == 16'd1) ? ST_CRC : ST_PAYLOAD;
                    bcnt_d        = 2'd0;
`ifdef CSI2_CRC_CHECK_EN
                    crc_en = 1'b1;
`endif
                end
                ST_CRC: begin
                    bcnt_d    = bcnt_q + 2'd1;
                    len_err_d = (bcnt_q == 2'd0) && rx_eot;
                    state_d   = ((bcnt_q != 2'd0) || rx_eot) ? ST_IDLE : ST_CRC;
`ifdef CSI2_CRC_CHECK_EN
                    crc_lo_d  = rx_data;
                    crc_err_d = (bcnt_q != 2'd0) && ({rx_data, crc_lo_q} != crc_val);
`endif
                end
                ST_DROP: state_d = rx_eot ? ST_IDLE : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            bcnt_q         <= 2'd0;
            di_q           <= 8'h00;
            wc_q           <= 16'h0000;
            cnt_q          <= 16'h0000;
            hdr_valid_q    <= 1'b0;
            vc_q           <= 2'd0;
            dt_q           <= 6'd0;
            word_count_q   <= 16'h0000;
            frame_valid_q  <= 1'b0;
            line_valid_q   <= 1'b0;
            frame_number_q <= 16'h0000;
            line_number_q  <= 16'h0000;
            pixel_data_q   <= 8'h00;
            pixel_valid_q  <= 1'b0;
            pixel_last_q   <= 1'b0;
            ecc_err_q      <= 1'b0;
            len_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bcnt_q         <= bcnt_d;
            di_q           <= di_d;
            wc_q           <= wc_d;
            cnt_q          <= cnt_d;
            hdr_valid_q    <= hdr_valid_d;
            vc_q           <= vc_d;
            dt_q           <= dt_d;
            word_count_q   <= word_count_d;
            frame_valid_q  <= frame_valid_d;
            line_valid_q   <= line_valid_d;
            frame_number_q <= frame_number_d;
            line_number_q  <= line_number_d;
            pixel_data_q   <= pixel_data_d;
            pixel_valid_q  <= pixel_valid_d;
            pixel_last_q   <= pixel_last_d;
            ecc_err_q      <= ecc_err_d;
            len_err_q      <= len_err_d;
        end
    end
`ifdef CSI2_CRC_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_err_q <= 1'b0;
            crc_lo_q  <= 8'h00;
        end else begin
            crc_err_q <= crc_err_d;
            crc_lo_q  <= crc_lo_d;
        end
    end
    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif
    assign hdr_valid    = hdr_valid_q;
    assign vc           = vc_q;
    assign dt           = dt_q;
    assign word_count   = word_count_q;
    assign frame_valid  = frame_valid_q;
    assign line_valid   = line_valid_q;
    assign frame_number = frame_number_q;
    assign line_number  = line_number_q;
    assign pixel_data   = pixel_data_q;
    assign pixel_valid  = pixel_valid_q;
    assign pixel_last   = pixel_last_q;
    assign ecc_err      = ecc_err_q;
    assign len_err      = len_err_q;
endmodule

// File: tb/tb_csi2_packet_decoder.sv
// tb_csi2_packet_decoder: table-driven short-packet vectors plus scoreboarded long-packet sequences
module tb_csi2_packet_decoder;
    logic        clk = 1'b0;
    logic        reset, rx_valid, rx_eot;
    logic [7:0]  rx_data;
    logic        hdr_valid, frame_valid, line_valid, pixel_valid, pixel_last;
    logic        ecc_err, crc_err, len_err;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] word_count, frame_number, line_number;
    logic [7:0]  pixel_data;
`ifdef CSI2_CRC_CHECK_EN
    localparam logic EXP_CRC = 1'b1;
`else
    localparam logic EXP_CRC = 1'b0;
`endif
    csi2_packet_decoder #(.MAX_WORD_COUNT(4096)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_eot(rx_eot),
        .hdr_valid(hdr_valid), .vc(vc), .dt(dt), .word_count(word_count),
        .frame_valid(frame_valid), .line_valid(line_valid),
        .frame_number(frame_number), .line_number(line_number),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_last(pixel_last),
        .ecc_err(ecc_err), .crc_err(crc_err), .len_err(len_err)
    );
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;
    int n_hdr = 0, n_ecc = 0, n_len = 0, n_crc = 0;
    logic gaps = 1'b0;
    typedef struct {logic [7:0] d; logic last;} pix_t;
    pix_t exp_q[$];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        n_hdr <= n_hdr + int'(hdr_valid);
        n_ecc <= n_ecc + int'(ecc_err);
        n_len <= n_len + int'(len_err);
        n_crc <= n_crc + int'(crc_err);
        if (pixel_valid) begin
            if (exp_q.size() == 0) chk("pix_unexpected", 64'(pixel_valid), 64'd0);
            else begin
                pix_t e;
                e = exp_q.pop_front();
                chk("pix_data", 64'(pixel_data), 64'(e.d));
                chk("pix_last", 64'(pixel_last), 64'(e.last));
            end
        end else if (pixel_last) chk("pix_last_stray", 64'(pixel_last), 64'd0);
    end
    function automatic logic [7:0] ref_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return {2'b00, p};
    endfunction
    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 16'h8408;
        end
        return r;
    endfunction
    task automatic put(input logic [7:0] b, input logic eot);
        if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        rx_valid = 1'b1;
        rx_data  = b;
        rx_eot   = eot;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_eot   = 1'b0;
    endtask
    task automatic settle();
        @(negedge clk);
        #1;
    endtask
    task automatic short_pkt(input logic [1:0] v, input logic [5:0] t, input logic [15:0] wc,
                             input logic flip, input logic eot);
        logic [7:0]  di  = {v, t};
        logic [7:0]  ecc = ref_ecc({wc, di});
        logic [15:0] wcs = wc ^ {15'd0, flip};
        put(di, 1'b0);
        put(wcs[7:0], 1'b0);
        put(wcs[15:8], 1'b0);
        put(ecc, eot);
    endtask
    task automatic long_pkt(input logic [5:0] t, input logic [15:0] wc, input int eot_at,
                            input logic [7:0] crc_xor);
        logic [15:0] c = 16'hFFFF;
        logic [7:0]  b;
        int n = int'(wc);
        short_pkt(2'd0, t, wc, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            b = 8'((i + 1) * 17);
            c = ref_crc(c, b);
            if (i == eot_at) begin
                exp_q.push_back('{b, 1'b0});
                put(b, 1'b1);
                return;
            end
            exp_q.push_back('{b, i == n - 1});
            put(b, 1'b0);
        end
        put(c[7:0] ^ crc_xor, 1'b0);
        put(c[15:8], 1'b1);
    endtask
    task automatic chk_zero(input string name);
        chk({name, "_a"}, {hdr_valid, vc, dt, frame_valid, line_valid, pixel_data, pixel_valid,
                           pixel_last, ecc_err, crc_err, len_err}, 64'd0);
        chk({name, "_b"}, {word_count, frame_number, line_number}, 64'd0);
    endtask
    typedef struct {
        logic [5:0]  t;
        logic [15:0] wc;
        logic        flip;
        logic        fv, lv;
        logic [15:0] fn, ln;
    } vec_t;
    vec_t tbl[9];
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        int h0, e0, l0, c0;
        tbl[0] = '{6'h00, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000};
        tbl[1] = '{6'h02, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0005};
        tbl[2] = '{6'h00, 16'h0007, 1'b0, 1'b1, 1'b1, 16'h0007, 16'h0005};
        tbl[3] = '{6'h03, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0007, 16'h0005};
        tbl[4] = '{6'h02, 16'h0009, 1'b0, 1'b1, 1'b1, 16'h0007, 16'h0009};
        tbl[5] = '{6'h01, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0007, 16'h0009};
        tbl[6] = '{6'h00, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0007, 16'h0009};
        tbl[7] = '{6'h08, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0007, 16'h0009};
        tbl[8] = '{6'h00, 16'h0003, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0009};
        reset = 1'b1; rx_valid = 1'b0; rx_eot = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            h0 = n_hdr; e0 = n_ecc;
            short_pkt(2'd1, tbl[i].t, tbl[i].wc, tbl[i].flip, 1'b0);
            if (tbl[i].flip) short_pkt(2'd1, 6'h00, 16'h0003, 1'b0, 1'b1);
            settle();
            chk($sformatf("v%0d_fv", i), 64'(frame_valid), 64'(tbl[i].fv));
            chk($sformatf("v%0d_lv", i), 64'(line_valid), 64'(tbl[i].lv));
            chk($sformatf("v%0d_fn", i), 64'(frame_number), 64'(tbl[i].fn));
            chk($sformatf("v%0d_ln", i), 64'(line_number), 64'(tbl[i].ln));
            chk($sformatf("v%0d_hdr", i), 64'(n_hdr - h0), 64'(!tbl[i].flip));
            chk($sformatf("v%0d_ecc", i), 64'(n_ecc - e0), 64'(tbl[i].flip));
            if (!tbl[i].flip) begin
                chk($sformatf("v%0d_dt", i), 64'(dt), 64'(tbl[i].t));
                chk($sformatf("v%0d_wc", i), 64'(word_count), 64'(tbl[i].wc));
                chk($sformatf("v%0d_vc", i), 64'(vc), 64'd1);
            end
        end
        short_pkt(2'd0, 6'h02, 16'h0005, 1'b0, 1'b0);
        c0 = n_crc; l0 = n_len;
        long_pkt(6'h2A, 16'd4, -1, 8'h00);
        chk("good_crc_now", 64'(crc_err), 64'd0);
        settle();
        chk("good_crc_cnt", 64'(n_crc - c0), 64'd0);
        chk("good_len_cnt", 64'(n_len - l0), 64'd0);
        chk("good_drain", 64'(exp_q.size()), 64'd0);
        chk("ls_lv", 64'(line_valid), 64'd1);
        short_pkt(2'd0, 6'h03, 16'h0000, 1'b0, 1'b1);
        settle();
        chk("le_lv", 64'(line_valid), 64'd0);
        c0 = n_crc;
        long_pkt(6'h2A, 16'd4, -1, 8'h01);
        chk("bad_crc_now", 64'(crc_err), 64'(EXP_CRC));
        settle();
        @(posedge clk);
        #1;
        chk("bad_crc_end", 64'(crc_err), 64'd0);
        chk("bad_crc_cnt", 64'(n_crc - c0), 64'(EXP_CRC));
        c0 = n_crc; h0 = n_hdr;
        long_pkt(6'h2B, 16'd0, -1, 8'h00);
        settle();
        chk("wc0_crc_cnt", 64'(n_crc - c0), 64'd0);
        chk("wc0_hdr_cnt", 64'(n_hdr - h0), 64'd1);
        l0 = n_len;
        long_pkt(6'h2A, 16'd8, 2, 8'h00);
        settle();
        chk("trunc_len_cnt", 64'(n_len - l0), 64'd1);
        chk("trunc_drain", 64'(exp_q.size()), 64'd0);
        h0 = n_hdr;
        short_pkt(2'd0, 6'h00, 16'h0010, 1'b0, 1'b1);
        settle();
        chk("after_trunc_hdr", 64'(n_hdr - h0), 64'd1);
        chk("after_trunc_fn", 64'(frame_number), 64'h10);
        l0 = n_len; h0 = n_hdr;
        short_pkt(2'd0, 6'h2A, 16'd5000, 1'b0, 1'b0);
        put(8'hAA, 1'b0);
        put(8'hBB, 1'b1);
        settle();
        chk("big_len_cnt", 64'(n_len - l0), 64'd1);
        chk("big_hdr_cnt", 64'(n_hdr - h0), 64'd1);
        chk("big_wc", 64'(word_count), 64'd5000);
        short_pkt(2'd0, 6'h01, 16'h0000, 1'b0, 1'b1);
        settle();
        chk("big_then_fe", 64'(frame_valid), 64'd0);
        gaps = 1'b1;
        c0 = n_crc;
        short_pkt(2'd0, 6'h00, 16'h0042, 1'b0, 1'b0);
        long_pkt(6'h2A, 16'd4, -1, 8'h00);
        settle();
        gaps = 1'b0;
        chk("gap_drain", 64'(exp_q.size()), 64'd0);
        chk("gap_crc_cnt", 64'(n_crc - c0), 64'd0);
        chk("gap_fn", 64'(frame_number), 64'h42);
        short_pkt(2'd0, 6'h2A, 16'd6, 1'b0, 1'b0);
        exp_q.push_back('{8'h11, 1'b0});
        put(8'h11, 1'b0);
        exp_q.push_back('{8'h22, 1'b0});
        put(8'h22, 1'b0);
        l0 = n_len; e0 = n_ecc; c0 = n_crc;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_zero("midreset");
        settle();
        chk("midreset_err", 64'((n_len - l0) + (n_ecc - e0) + (n_crc - c0)), 64'd0);
        long_pkt(6'h2A, 16'd4, -1, 8'h00);
        settle();
        chk("postreset_drain", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csi2_packet_decoder.md
# csi2_packet_decoder

Byte-level CSI-2 packet decoder that sits directly downstream of the D-PHY lane deserializer. It consumes the merged HS byte stream, parses and ECC-checks 32-bit packet headers, tracks frame/line state from short packets, and streams long-packet payload bytes out as pixel bytes. Optionally, it checks the payload CRC-16. Its outputs feed the pixel unpacker and the status registers.

## Interface
- MAX_WORD_COUNT, 4096: largest accepted long-packet word count. Larger values set len_err and drop the packet.
- clk  in  1  byte clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  rx_data holds a valid HS byte this cycle
- rx_data  in  8  HS byte, packet-order
- rx_eot  in  1  end of HS burst; qualified by rx_valid (marks last byte)
- hdr_valid  out  1  one-cycle pulse: good header decoded
- vc  out  2  virtual channel of last good header
- dt  out  6  data type of last good header
- word_count  out  16  WC field of last good header
- frame_valid  out  1  between FS and FE
- line_valid  out  1  between LS and LE
- frame_number  out  16  WC of last FS
- line_number  out  16  WC of last LS
- pixel_data  out  8  payload byte
- pixel_valid  out  1  pixel_data valid
- pixel_last  out  1  with pixel_valid: final payload byte of packet
- ecc_err  out  1  one-cycle pulse: header ECC mismatch
- crc_err  out  1  one-cycle pulse: payload CRC mismatch
- len_err  out  1  one-cycle pulse: WC > MAX_WORD_COUNT, or burst ended early

## Operation
- Reset drives every output and all internal registers to 0. The FSM goes to IDLE.
- FSM states: IDLE, HEADER, PAYLOAD, CRC, DROP. States advance only on cycles with rx_valid=1; bubbles hold all state.
- IDLE: a valid byte is latched as DI; go to HEADER with hdr_cnt=1.
- HEADER: the next bytes are WC[7:0], WC[15:8], then ECC.
  - On the ECC byte, compare it against ecc6({WC,DI}) with the top 2 bits zero.
  - On mismatch: pulse ecc_err. If this byte carries rx_eot, go to IDLE; otherwise go to DROP. No correction is attempted.
  - On match: pulse hdr_valid and update vc, dt and word_count.
- Short packet (DT 0x00–0x0F): FS sets frame_valid and frame_number=WC. FE clears frame_valid and line_valid. LS sets line_valid and line_number=WC. LE clears line_valid. Other short DTs raise hdr_valid only. Then go to IDLE.
- Long packet (DT ≥ 0x10):
  - If WC > MAX_WORD_COUNT: pulse len_err, go to DROP.
  - If WC = 0: go straight to CRC.
  - Otherwise: go to PAYLOAD with byte counter = WC.
- PAYLOAD: each valid byte is output on pixel_data with pixel_valid, and the counter decrements. The byte at counter = 1 also asserts pixel_last, then the FSM goes to CRC.
- CRC: two bytes, LSB first, then go to IDLE.
- DROP: discard bytes until rx_eot, then go to IDLE.
- rx_eot in HEADER, PAYLOAD, or CRC before the packet completes: pulse len_err and go to IDLE. pixel_last is not asserted. The byte carrying rx_eot is still emitted if in PAYLOAD.
- rx_eot on the final byte of a packet is normal: go to IDLE with no error.
- FS while frame_valid=1: update frame_number; frame_valid stays 1.
- FE while line_valid=1: clear both frame_valid and line_valid in the same cycle.

## Timing
- All outputs are registered. Latency is 1 cycle from the accepting edge of a byte to its effect.
- pixel_data and pixel_valid appear 1 cycle after the payload byte is accepted.
- hdr_valid, ecc_err and the frame/line updates appear 1 cycle after the ECC byte.
- crc_err appears 1 cycle after the second CRC byte.
- All pulses last exactly 1 cycle.
- Throughput is 1 byte per cycle with no backpressure; rx_valid gaps of any length are tolerated.
- A new header byte is accepted in the cycle right after the last CRC byte or short-packet ECC byte.
- Reset asserted mid-packet: the next cycle is IDLE with all outputs 0. No error pulse is generated.

## Configuration
- CSI2_CRC_CHECK_EN defined:
  - CRC-16 (poly 0x1021, reflected form 0x8408, init 0xFFFF, LSB-first) runs over the payload bytes.
  - The CRC is cleared on entering PAYLOAD (or CRC when WC=0).
  - Received CRC {byte1,byte0} ≠ computed value → crc_err.
  - WC=0 expects 0xFFFF.
- Undefined: the CRC bytes are consumed and ignored; crc_err is tied to 0; no CRC logic is synthesized.

## Structure
- Package csi2_pkg: data-type localparams (DT_FS=0x00, DT_FE=0x01, DT_LS=0x02, DT_LE=0x03, DT_LONG_MIN=0x10), the FSM state enum, function ecc6(24-bit) per the CSI-2 v1.x parity matrix, and function crc16_byte(crc, byte). These are shared with the TX model checker.
- Sub-module csi2_crc16: byte-wide CRC accumulator (clear, en, data, crc out). It is instantiated only under CSI2_CRC_CHECK_EN.

## Test plan
- Send FS DI=0x00 WC=0x0001 with a valid ECC → hdr_valid pulse; frame_valid=1 and frame_number=1 one cycle after byte 4. Then send FE → frame_valid=0.
- Send LS WC=0x0005, then long packet DT=0x2A WC=4 with payload 0x11,0x22,0x33,0x44 and correct CRC, then LE → four pixel_valid cycles with matching data; pixel_last only on 0x44; crc_err=0; line_valid 1→0 after LE.
- Send the same long packet with its CRC low byte flipped → crc_err pulses once, 1 cycle after the last CRC byte. Without the macro, crc_err stays 0.
- Flip bit 0 of WC in a short packet → ecc_err pulse; frame/line state unchanged. The rest of the burst is dropped until rx_eot, and the next burst decodes normally.
- Send DT=0x2A WC=8 with rx_eot on payload byte 3 → 3 pixel bytes, no pixel_last, len_err pulse; the next header is accepted. Separately, WC=5000 → len_err and DROP.
- Insert random rx_valid gaps plus a reset mid-payload → output data is identical to the no-gap run, and all outputs are 0 the cycle after reset.
